// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: multi-channel LED driver (OFF/ON/BLINK/BREATHE) with shared prescaler and PWM frame counter.
// Optional feature macro: LED_BREATHE_EN builds the breathing engine; without it mode 3 behaves as ON.
module led_pwm_ctrl #(
    parameter int CH_NUM  = 4,
    parameter int PWM_W   = 8,
    parameter int DIV_W   = 16,
    parameter bit LED_POL = 1'b1,
    localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  div,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [PWM_W-1:0]  cfg_duty,
    input  logic [7:0]        cfg_period,
    output logic              tick,
    output logic [CH_NUM-1:0] led
);
    logic [DIV_W-1:0]  div_cnt;
    logic [PWM_W-1:0]  pwm_cnt;
    logic              fe;
    logic [CH_NUM-1:0] level;

    assign fe = tick && (pwm_cnt == '1);

    // prescaler (>= compare so a smaller reload wraps at once) and PWM frame counter advancing on tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
            pwm_cnt <= '0;
        end else begin
            tick    <= div_cnt >= div;
            div_cnt <= (div_cnt >= div) ? '0 : div_cnt + DIV_W'(1);
            if (tick)
                pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(i);
        logic             wr;
        logic [1:0]       mode;
        logic [PWM_W-1:0] duty;
        logic [7:0]       period;
        logic [7:0]       frm_cnt;
        logic             phase;
        logic             on_lvl;
        logic             br;

        assign wr     = cfg_wr && (cfg_ch == IDX);
        assign on_lvl = (pwm_cnt < duty) || (&duty);

        // channel config and blink frame counter; a write overrides a coincident frame end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode    <= 2'd0;
                duty    <= '0;
                period  <= '0;
                frm_cnt <= '0;
                phase   <= 1'b0;
            end else if (wr) begin
                mode    <= cfg_mode;
                duty    <= cfg_duty;
                period  <= cfg_period;
                frm_cnt <= '0;
                phase   <= 1'b1;
            end else if (fe) begin
                frm_cnt <= (frm_cnt == period) ? '0 : frm_cnt + 8'd1;
                phase   <= phase ^ (frm_cnt == period);
            end
        end

`ifdef LED_BREATHE_EN
        logic [PWM_W-1:0] lvl;
        logic [PWM_W-1:0] lvl_nxt;
        logic             dir;

        assign lvl_nxt = dir ? lvl - PWM_W'(1) : lvl + PWM_W'(1);
        assign br      = pwm_cnt < lvl;

        // breathing ramp: one step per (period+1) frames, turning around at full scale and at zero
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lvl <= '0;
                dir <= 1'b0;
            end else if (wr) begin
                lvl <= '0;
                dir <= 1'b0;
            end else if (fe && mode == 2'd3 && frm_cnt == period) begin
                lvl <= lvl_nxt;
                dir <= dir ? (lvl_nxt != '0) : (lvl_nxt == '1);
            end
        end
`else
        assign br = on_lvl;
`endif

        assign level[i] = (mode == 2'd1) ? on_lvl :
                          (mode == 2'd2) ? (phase & on_lvl) :
                          (mode == 2'd3) ? br : 1'b0;
    end

    // registered LED drive with output polarity applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            led <= {CH_NUM{~LED_POL}};
        else
            led <= level ~^ {CH_NUM{LED_POL}};
    end
endmodule

// File: tb/tb_led_pwm_ctrl.sv
// tb_led_pwm_ctrl: directed bench for led_pwm_ctrl; dut is 4-channel active-high, dut_n is 3-channel active-low.
module tb_led_pwm_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] div;
    logic        cfg_wr;
    logic [1:0]  cfg_ch;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_duty;
    logic [7:0]  cfg_period;
    logic        tick, tick_n;
    logic [3:0]  led;
    logic [2:0]  led_n;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    led_pwm_ctrl #(.CH_NUM(4), .PWM_W(8), .DIV_W(16), .LED_POL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .div(div), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .cfg_period(cfg_period),
        .tick(tick), .led(led)
    );

    led_pwm_ctrl #(.CH_NUM(3), .PWM_W(8), .DIV_W(16), .LED_POL(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .div(div), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .cfg_period(cfg_period),
        .tick(tick_n), .led(led_n)
    );

    task automatic wr(input logic [1:0] ch, input logic [1:0] m, input logic [7:0] d, input logic [7:0] p);
        cfg_ch = ch; cfg_mode = m; cfg_duty = d; cfg_period = p; cfg_wr = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic count(input int ch, input int n, output int hi, output int lo_n);
        hi = 0; lo_n = 0;
        repeat (n) begin
            @(negedge clk);
            if (led[ch] === 1'b1) hi++;
            if (ch < 3 && led_n[ch] === 1'b0) lo_n++;
        end
    endtask

    task automatic run_len(input int ch, input logic v, output int len);
        len = 0;
        while (led[ch] === v && len < 1100) begin
            @(negedge clk);
            len++;
        end
    endtask

    task automatic wait_marker;
        int t = 0;
        while (led[0] !== 1'b1 && t < 600) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (led[0] !== 1'b1) begin
            n_err++;
            $display("FAIL marker: led[0] got %b want 1 within 600 cycles", led[0]);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; div = '0; cfg_wr = 1'b0;
        cfg_ch = 2'd0; cfg_mode = 2'd1; cfg_duty = 8'd255; cfg_period = 8'd0;
        repeat (5) begin
            @(negedge clk);
            cfg_wr = ~cfg_wr;
            n_cmp++;
            if (led !== 4'b0000 || tick !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hi: led=%b tick=%b want 0000/0", led, tick);
            end
            n_cmp++;
            if (led_n !== 3'b111 || tick_n !== 1'b0) begin
                n_err++;
                $display("FAIL reset_lo: led_n=%b tick_n=%b want 111/0", led_n, tick_n);
            end
        end
        cfg_wr = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (tick !== 1'b1 || led !== 4'b0000 || led_n !== 3'b111) begin
            n_err++;
            $display("FAIL post_reset: tick=%b led=%b led_n=%b want 1/0000/111", tick, led, led_n);
        end
    endtask

    task automatic test_ignore;
        int hi = 0;
        int bad = 0;
        wr(2'd3, 2'd1, 8'd255, 8'd0);
        repeat (300) begin
            @(negedge clk);
            if (led[3] === 1'b1) hi++;
            if (led_n !== 3'b111 || led[2:0] !== 3'b000) bad++;
        end
        n_cmp++;
        if (hi != 300) begin
            n_err++;
            $display("FAIL ch3_on: high=%0d want 300", hi);
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL ignore_oob: changed samples=%0d want 0", bad);
        end
    endtask

    task automatic test_on;
        int hi, lo_n;
        wr(2'd0, 2'd1, 8'd64, 8'd0);
        repeat (2) begin
            count(0, 256, hi, lo_n);
            n_cmp++;
            if (hi != 64 || lo_n != 64) begin
                n_err++;
                $display("FAIL on_64: high=%0d low_n=%0d want 64/64", hi, lo_n);
            end
        end
        wr(2'd0, 2'd1, 8'd255, 8'd0);
        count(0, 256, hi, lo_n);
        n_cmp++;
        if (hi != 256 || lo_n != 256) begin
            n_err++;
            $display("FAIL on_255: high=%0d low_n=%0d want 256/256", hi, lo_n);
        end
        wr(2'd0, 2'd1, 8'd0, 8'd0);
        count(0, 256, hi, lo_n);
        n_cmp++;
        if (hi != 0 || lo_n != 0) begin
            n_err++;
            $display("FAIL on_0: high=%0d low_n=%0d want 0/0", hi, lo_n);
        end
        wr(2'd0, 2'd1, 8'd1, 8'd0);
    endtask

    task automatic test_blink;
        int len;
        wr(2'd1, 2'd2, 8'd255, 8'd1);
        @(negedge clk);
        n_cmp++;
        if (led[1] !== 1'b1 || led_n[1] !== 1'b0) begin
            n_err++;
            $display("FAIL blink_start: led[1]=%b led_n[1]=%b want 1/0", led[1], led_n[1]);
        end
        run_len(1, 1'b1, len);
        run_len(1, 1'b0, len);
        n_cmp++;
        if (len != 512) begin
            n_err++;
            $display("FAIL blink_low1: len=%0d want 512", len);
        end
        run_len(1, 1'b1, len);
        n_cmp++;
        if (len != 512) begin
            n_err++;
            $display("FAIL blink_high: len=%0d want 512", len);
        end
        run_len(1, 1'b0, len);
        n_cmp++;
        if (len != 512) begin
            n_err++;
            $display("FAIL blink_low2: len=%0d want 512", len);
        end
    endtask

    task automatic test_fe_collision;
        int hi, lo_n;
        wait_marker();
        wr(2'd1, 2'd2, 8'd255, 8'd0);
        repeat (253) @(negedge clk);
        wr(2'd1, 2'd2, 8'd255, 8'd0);
        count(1, 256, hi, lo_n);
        n_cmp++;
        if (hi != 256 || lo_n != 256) begin
            n_err++;
            $display("FAIL fe_wr_wins: high=%0d low_n=%0d want 256/256", hi, lo_n);
        end
        @(negedge clk);
        n_cmp++;
        if (led[1] !== 1'b0) begin
            n_err++;
            $display("FAIL fe_wr_next: led[1]=%b want 0", led[1]);
        end
    endtask

    task automatic test_breathe;
        int hi, lo_n, exp;
        wait_marker();
        repeat (254) @(negedge clk);
        wr(2'd2, 2'd3, 8'd100, 8'd0);
`ifdef LED_BREATHE_EN
        for (int k = 0; k < 258; k++) begin
            exp = (k <= 255) ? k : 510 - k;
            count(2, 256, hi, lo_n);
            n_cmp++;
            if (hi != exp || lo_n != exp) begin
                n_err++;
                $display("FAIL breathe_f%0d: high=%0d low_n=%0d want %0d", k, hi, lo_n, exp);
            end
        end
`else
        for (int k = 0; k < 4; k++) begin
            count(2, 256, hi, lo_n);
            n_cmp++;
            if (hi != 100 || lo_n != 100) begin
                n_err++;
                $display("FAIL breathe_as_on_f%0d: high=%0d low_n=%0d want 100", k, hi, lo_n);
            end
        end
`endif
    endtask

    task automatic test_prescaler;
        logic [10:0] pat;
        logic [8:0]  pat2;
        int t = 0;
        div = 16'd10;
        @(negedge clk);
        while (tick !== 1'b1 && t < 30) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (tick !== 1'b1) begin
            n_err++;
            $display("FAIL div10_first: tick=%b want 1 within 30 cycles", tick);
        end
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            pat[k] = tick;
        end
        n_cmp++;
        if (pat !== 11'b100_0000_0000) begin
            n_err++;
            $display("FAIL div10_period: pattern=%b want 10000000000", pat);
        end
        repeat (7) @(negedge clk);
        div = 16'd3;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            pat2[k] = tick;
        end
        n_cmp++;
        if (pat2 !== 9'b1_0001_0001) begin
            n_err++;
            $display("FAIL div_shrink: pattern=%b want 100010001", pat2);
        end
        div = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mid_reset;
        int bad = 0;
        wr(2'd1, 2'd2, 8'd255, 8'd1);
        @(negedge clk);
        n_cmp++;
        if (led[1] !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre: led[1]=%b want 1", led[1]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (led !== 4'b0000 || led_n !== 3'b111 || tick !== 1'b0) begin
            n_err++;
            $display("FAIL mid_async: led=%b led_n=%b tick=%b want 0000/111/0", led, led_n, tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (600) begin
            @(negedge clk);
            if (led !== 4'b0000 || led_n !== 3'b111) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL mid_after: active samples=%0d want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_ignore();
        test_on();
        test_blink();
        test_fe_collision();
        test_breathe();
        test_prescaler();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
